// File: rtl/id_stage_pkg.sv
// Shared encodings for the instruction-decode stage: ISA opcodes, ALU ops,
// memory operations and exception codes.
package id_stage_pkg;

  localparam int WORD_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [5:0] {
    OP_AND   = 6'h00,
    OP_ANDI  = 6'h01,
    OP_OR    = 6'h02,
    OP_ORI   = 6'h03,
    OP_XOR   = 6'h04,
    OP_XORI  = 6'h05,
    OP_ADDSR = 6'h06,
    OP_ADDSI = 6'h07,
    OP_ADDUR = 6'h08,
    OP_ADDUI = 6'h09,
    OP_SUBSR = 6'h0A,
    OP_SUBUR = 6'h0B,
    OP_SHRLR = 6'h0C,
    OP_SHRLI = 6'h0D,
    OP_SHLLR = 6'h0E,
    OP_SHLLI = 6'h0F,
    OP_BE    = 6'h10,
    OP_BNE   = 6'h11,
    OP_LDW   = 6'h16,
    OP_STW   = 6'h17
  } isa_op_e;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_AND  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_ADDS = 4'd4,
    ALU_ADDU = 4'd5,
    ALU_SUBS = 4'd6,
    ALU_SUBU = 4'd7,
    ALU_SHRL = 4'd8,
    ALU_SHLL = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    EXP_NONE  = 2'd0,
    EXP_UNDEF = 2'd1
  } exp_code_e;

endpackage

// File: rtl/id_stage_decoder.sv
// Combinational decode of the fetched word: operand forwarding from EX,
// load-use hazard detection and BE/BNE resolution.
module id_stage_decoder
  import id_stage_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              if_en,
  input  logic [WORD_W-1:0] if_pc,
  input  logic [WORD_W-1:0] if_insn,
  output logic [REG_AW-1:0] gpr_rd_addr_0,
  output logic [REG_AW-1:0] gpr_rd_addr_1,
  input  logic [WORD_W-1:0] gpr_rd_data_0,
  input  logic [WORD_W-1:0] gpr_rd_data_1,
  input  logic              ex_en,
  input  logic              ex_gpr_we,
  input  logic [REG_AW-1:0] ex_dst_addr,
  input  logic [1:0]        ex_mem_op,
  input  logic [WORD_W-1:0] ex_fwd_data,
  output logic              ld_hazard,
  output logic              br_taken,
  output logic [WORD_W-1:0] br_addr,
  output logic [3:0]        alu_op,
  output logic [WORD_W-1:0] alu_in_0,
  output logic [WORD_W-1:0] alu_in_1,
  output logic [REG_AW-1:0] dst_addr,
  output logic              gpr_we,
  output logic [1:0]        mem_op,
  output logic [WORD_W-1:0] mem_wr_data,
  output logic [1:0]        exp_code
);

  logic [5:0]        op;
  logic [REG_AW-1:0] ra_addr;
  logic [REG_AW-1:0] rb_addr;
  logic [REG_AW-1:0] rc_addr;
  logic [15:0]       imm;
  logic [WORD_W-1:0] imm_zext;
  logic [WORD_W-1:0] imm_sext;
  logic [WORD_W-1:0] imm_shamt;
  logic [WORD_W-1:0] ra_data;
  logic [WORD_W-1:0] rb_data;
  logic              ex_writes;
  logic              reads_rb;
  logic              is_branch;
  logic              branch_ne;

  assign op        = if_insn[31:26];
  assign ra_addr   = if_insn[25:21];
  assign rb_addr   = if_insn[20:16];
  assign rc_addr   = if_insn[15:11];
  assign imm       = if_insn[15:0];
  assign imm_zext  = {{(WORD_W-16){1'b0}}, imm};
  assign imm_sext  = {{(WORD_W-16){imm[15]}}, imm};
  assign imm_shamt = {{(WORD_W-5){1'b0}}, imm[4:0]};

  assign gpr_rd_addr_0 = ra_addr;
  assign gpr_rd_addr_1 = rb_addr;

  // EX result bypasses the register file; r0 is an ordinary register here.
  assign ex_writes = ex_en && ex_gpr_we;
  assign ra_data   = (ex_writes && ex_dst_addr == ra_addr) ? ex_fwd_data : gpr_rd_data_0;
  assign rb_data   = (ex_writes && ex_dst_addr == rb_addr) ? ex_fwd_data : gpr_rd_data_1;

  always_comb begin
    alu_op      = ALU_NOP;
    alu_in_0    = ra_data;
    alu_in_1    = rb_data;
    dst_addr    = '0;
    gpr_we      = 1'b0;
    mem_op      = MEM_NONE;
    mem_wr_data = '0;
    exp_code    = EXP_NONE;
    reads_rb    = 1'b0;
    is_branch   = 1'b0;
    branch_ne   = 1'b0;
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_ADDSR, OP_ADDUR,
      OP_SUBSR, OP_SUBUR, OP_SHRLR, OP_SHLLR: begin
        dst_addr = rc_addr;
        gpr_we   = 1'b1;
        reads_rb = 1'b1;
        case (op)
          OP_AND:   alu_op = ALU_AND;
          OP_OR:    alu_op = ALU_OR;
          OP_XOR:   alu_op = ALU_XOR;
          OP_ADDSR: alu_op = ALU_ADDS;
          OP_ADDUR: alu_op = ALU_ADDU;
          OP_SUBSR: alu_op = ALU_SUBS;
          OP_SUBUR: alu_op = ALU_SUBU;
          OP_SHRLR: alu_op = ALU_SHRL;
          default:  alu_op = ALU_SHLL;
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        alu_in_1 = imm_zext;
        dst_addr = rb_addr;
        gpr_we   = 1'b1;
        alu_op   = (op == OP_ANDI) ? ALU_AND : (op == OP_ORI) ? ALU_OR : ALU_XOR;
      end
      OP_ADDSI, OP_ADDUI: begin
        alu_in_1 = imm_sext;
        dst_addr = rb_addr;
        gpr_we   = 1'b1;
        alu_op   = (op == OP_ADDSI) ? ALU_ADDS : ALU_ADDU;
      end
      OP_SHRLI, OP_SHLLI: begin
        alu_in_1 = imm_shamt;
        dst_addr = rb_addr;
        gpr_we   = 1'b1;
        alu_op   = (op == OP_SHRLI) ? ALU_SHRL : ALU_SHLL;
      end
      OP_LDW: begin
        alu_op   = ALU_ADDU;
        alu_in_1 = imm_sext;
        dst_addr = rb_addr;
        gpr_we   = 1'b1;
        mem_op   = MEM_LOAD;
      end
      OP_STW: begin
        alu_op      = ALU_ADDU;
        alu_in_1    = imm_sext;
        mem_op      = MEM_STORE;
        mem_wr_data = rb_data;
        reads_rb    = 1'b1;
      end
      OP_BE, OP_BNE: begin
        reads_rb  = 1'b1;
        is_branch = 1'b1;
        branch_ne = (op == OP_BNE);
      end
      default: exp_code = EXP_UNDEF;
    endcase
  end

  assign ld_hazard = if_en && ex_writes && (ex_mem_op == MEM_LOAD) &&
                     ((ex_dst_addr == ra_addr) || (reads_rb && ex_dst_addr == rb_addr));

  assign br_taken = if_en && !ld_hazard && is_branch &&
                    (branch_ne ? (ra_data != rb_data) : (ra_data == rb_data));
  assign br_addr  = if_pc + WORD_W'(4) + (imm_sext << 2);

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: combinational decoder followed by the ID/EX
// pipeline register feeding the execute-stage ALU.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              if_en,
  input  logic [WORD_W-1:0] if_pc,
  input  logic [WORD_W-1:0] if_insn,
  output logic [REG_AW-1:0] gpr_rd_addr_0,
  output logic [REG_AW-1:0] gpr_rd_addr_1,
  input  logic [WORD_W-1:0] gpr_rd_data_0,
  input  logic [WORD_W-1:0] gpr_rd_data_1,
  input  logic              ex_en,
  input  logic              ex_gpr_we,
  input  logic [REG_AW-1:0] ex_dst_addr,
  input  logic [1:0]        ex_mem_op,
  input  logic [WORD_W-1:0] ex_fwd_data,
  output logic              ld_hazard,
  output logic              br_taken,
  output logic [WORD_W-1:0] br_addr,
  output logic              id_en,
  output logic              id_gpr_we,
  output logic [WORD_W-1:0] id_pc,
  output logic [3:0]        id_alu_op,
  output logic [WORD_W-1:0] id_alu_in_0,
  output logic [WORD_W-1:0] id_alu_in_1,
  output logic [REG_AW-1:0] id_dst_addr,
  output logic [1:0]        id_mem_op,
  output logic [WORD_W-1:0] id_mem_wr_data,
  output logic [1:0]        id_exp_code
);

  logic [3:0]        dec_alu_op;
  logic [WORD_W-1:0] dec_alu_in_0;
  logic [WORD_W-1:0] dec_alu_in_1;
  logic [REG_AW-1:0] dec_dst_addr;
  logic              dec_gpr_we;
  logic [1:0]        dec_mem_op;
  logic [WORD_W-1:0] dec_mem_wr_data;
  logic [1:0]        dec_exp_code;

  logic              en_q,   en_d;
  logic              we_q,   we_d;
  logic [WORD_W-1:0] pc_q,   pc_d;
  logic [3:0]        aop_q,  aop_d;
  logic [WORD_W-1:0] in0_q,  in0_d;
  logic [WORD_W-1:0] in1_q,  in1_d;
  logic [REG_AW-1:0] dst_q,  dst_d;
  logic [1:0]        mop_q,  mop_d;
  logic [WORD_W-1:0] wdat_q, wdat_d;
  logic [1:0]        exc_q,  exc_d;

  id_stage_decoder #(
    .WORD_W(WORD_W),
    .REG_AW(REG_AW)
  ) u_decoder (
    .if_en        (if_en),
    .if_pc        (if_pc),
    .if_insn      (if_insn),
    .gpr_rd_addr_0(gpr_rd_addr_0),
    .gpr_rd_addr_1(gpr_rd_addr_1),
    .gpr_rd_data_0(gpr_rd_data_0),
    .gpr_rd_data_1(gpr_rd_data_1),
    .ex_en        (ex_en),
    .ex_gpr_we    (ex_gpr_we),
    .ex_dst_addr  (ex_dst_addr),
    .ex_mem_op    (ex_mem_op),
    .ex_fwd_data  (ex_fwd_data),
    .ld_hazard    (ld_hazard),
    .br_taken     (br_taken),
    .br_addr      (br_addr),
    .alu_op       (dec_alu_op),
    .alu_in_0     (dec_alu_in_0),
    .alu_in_1     (dec_alu_in_1),
    .dst_addr     (dec_dst_addr),
    .gpr_we       (dec_gpr_we),
    .mem_op       (dec_mem_op),
    .mem_wr_data  (dec_mem_wr_data),
    .exp_code     (dec_exp_code)
  );

  // A bubble is identical to the reset image, so flush and hazards reuse it.
  always_comb begin
    en_d   = en_q;
    we_d   = we_q;
    pc_d   = pc_q;
    aop_d  = aop_q;
    in0_d  = in0_q;
    in1_d  = in1_q;
    dst_d  = dst_q;
    mop_d  = mop_q;
    wdat_d = wdat_q;
    exc_d  = exc_q;
    if (flush || (!stall && (ld_hazard || !if_en))) begin
      en_d   = 1'b0;
      we_d   = 1'b0;
      pc_d   = '0;
      aop_d  = ALU_NOP;
      in0_d  = '0;
      in1_d  = '0;
      dst_d  = '0;
      mop_d  = MEM_NONE;
      wdat_d = '0;
      exc_d  = EXP_NONE;
    end else if (!stall) begin
      en_d   = 1'b1;
      we_d   = dec_gpr_we;
      pc_d   = if_pc;
      aop_d  = dec_alu_op;
      in0_d  = dec_alu_in_0;
      in1_d  = dec_alu_in_1;
      dst_d  = dec_dst_addr;
      mop_d  = dec_mem_op;
      wdat_d = dec_mem_wr_data;
      exc_d  = dec_exp_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q   <= 1'b0;
      we_q   <= 1'b0;
      pc_q   <= '0;
      aop_q  <= ALU_NOP;
      in0_q  <= '0;
      in1_q  <= '0;
      dst_q  <= '0;
      mop_q  <= MEM_NONE;
      wdat_q <= '0;
      exc_q  <= EXP_NONE;
    end else begin
      en_q   <= en_d;
      we_q   <= we_d;
      pc_q   <= pc_d;
      aop_q  <= aop_d;
      in0_q  <= in0_d;
      in1_q  <= in1_d;
      dst_q  <= dst_d;
      mop_q  <= mop_d;
      wdat_q <= wdat_d;
      exc_q  <= exc_d;
    end
  end

  assign id_en          = en_q;
  assign id_gpr_we      = we_q;
  assign id_pc          = pc_q;
  assign id_alu_op      = aop_q;
  assign id_alu_in_0    = in0_q;
  assign id_alu_in_1    = in1_q;
  assign id_dst_addr    = dst_q;
  assign id_mem_op      = mop_q;
  assign id_mem_wr_data = wdat_q;
  assign id_exp_code    = exc_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios followed by random
// traffic, all compared against an instruction-level reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, if_en;
  logic [31:0] if_pc, if_insn;
  logic [4:0]  gpr_rd_addr_0, gpr_rd_addr_1;
  logic [31:0] gpr_rd_data_0, gpr_rd_data_1;
  logic        ex_en, ex_gpr_we;
  logic [4:0]  ex_dst_addr;
  logic [1:0]  ex_mem_op;
  logic [31:0] ex_fwd_data;
  logic        ld_hazard, br_taken;
  logic [31:0] br_addr;
  logic        id_en, id_gpr_we;
  logic [31:0] id_pc;
  logic [3:0]  id_alu_op;
  logic [31:0] id_alu_in_0, id_alu_in_1;
  logic [4:0]  id_dst_addr;
  logic [1:0]  id_mem_op;
  logic [31:0] id_mem_wr_data;
  logic [1:0]  id_exp_code;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .if_en(if_en), .if_pc(if_pc), .if_insn(if_insn),
    .gpr_rd_addr_0(gpr_rd_addr_0), .gpr_rd_addr_1(gpr_rd_addr_1),
    .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
    .ex_en(ex_en), .ex_gpr_we(ex_gpr_we), .ex_dst_addr(ex_dst_addr),
    .ex_mem_op(ex_mem_op), .ex_fwd_data(ex_fwd_data),
    .ld_hazard(ld_hazard), .br_taken(br_taken), .br_addr(br_addr),
    .id_en(id_en), .id_gpr_we(id_gpr_we), .id_pc(id_pc),
    .id_alu_op(id_alu_op), .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1),
    .id_dst_addr(id_dst_addr), .id_mem_op(id_mem_op),
    .id_mem_wr_data(id_mem_wr_data), .id_exp_code(id_exp_code)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Expected ID/EX contents; c_* mark fields the instruction actually defines.
  typedef struct {
    logic        en, we;
    logic [31:0] pc;
    logic [3:0]  aop;
    logic [31:0] in0, in1;
    logic [4:0]  dst;
    logic [1:0]  mop;
    logic [31:0] wd;
    logic [1:0]  exc;
    bit          c_in, c_dst, c_wd;
  } exp_t;

  exp_t e;

  function automatic exp_t bubble();
    exp_t b;
    b = '{en:0, we:0, pc:0, aop:0, in0:0, in1:0, dst:0, mop:0, wd:0, exc:0,
          c_in:1, c_dst:1, c_wd:1};
    return b;
  endfunction

  // kind: 0 undef, 1 R-type, 2 imm zext, 3 imm sext, 4 shift imm, 5 LDW, 6 STW, 7 BE, 8 BNE
  function automatic void op_info(input logic [5:0] op, output int kind, output logic [3:0] aop);
    kind = 0; aop = 0;
    case (op)
      6'h00: begin kind = 1; aop = 1; end
      6'h01: begin kind = 2; aop = 1; end
      6'h02: begin kind = 1; aop = 2; end
      6'h03: begin kind = 2; aop = 2; end
      6'h04: begin kind = 1; aop = 3; end
      6'h05: begin kind = 2; aop = 3; end
      6'h06: begin kind = 1; aop = 4; end
      6'h07: begin kind = 3; aop = 4; end
      6'h08: begin kind = 1; aop = 5; end
      6'h09: begin kind = 3; aop = 5; end
      6'h0A: begin kind = 1; aop = 6; end
      6'h0B: begin kind = 1; aop = 7; end
      6'h0C: begin kind = 1; aop = 8; end
      6'h0D: begin kind = 4; aop = 8; end
      6'h0E: begin kind = 1; aop = 9; end
      6'h0F: begin kind = 4; aop = 9; end
      6'h10: kind = 7;
      6'h11: kind = 8;
      6'h16: begin kind = 5; aop = 5; end
      6'h17: begin kind = 6; aop = 5; end
      default: kind = 0;
    endcase
  endfunction

  // One clock: check combinational outputs, advance the model, check registers.
  task automatic cycle();
    logic [5:0]  op;
    logic [4:0]  ra, rb, rc;
    logic [15:0] imm;
    logic [31:0] ra_d, rb_d, expect_br;
    int          kind, simm;
    logic [3:0]  aop;
    bit          rrb, haz, btk;
    exp_t        d;
    #1;
    op  = if_insn[31:26];
    ra  = if_insn[25:21];
    rb  = if_insn[20:16];
    rc  = if_insn[15:11];
    imm = if_insn[15:0];
    simm = $signed(imm);
    ra_d = (ex_en && ex_gpr_we && ex_dst_addr == ra) ? ex_fwd_data : gpr_rd_data_0;
    rb_d = (ex_en && ex_gpr_we && ex_dst_addr == rb) ? ex_fwd_data : gpr_rd_data_1;
    op_info(op, kind, aop);
    rrb = (kind == 1) || (kind == 6) || (kind == 7) || (kind == 8);
    haz = if_en && ex_en && ex_gpr_we && ex_mem_op == 2'd1 &&
          (ex_dst_addr == ra || (rrb && ex_dst_addr == rb));
    btk = if_en && !haz && ((kind == 7 && ra_d == rb_d) || (kind == 8 && ra_d != rb_d));
    expect_br = if_pc + 32'd4 + 32'(simm * 4);
    chk("gpr_rd_addr_0", gpr_rd_addr_0, ra);
    chk("gpr_rd_addr_1", gpr_rd_addr_1, rb);
    chk("ld_hazard", ld_hazard, haz);
    chk("br_taken", br_taken, btk);
    chk("br_addr", br_addr, expect_br);

    d = bubble();
    d.en = 1; d.pc = if_pc; d.aop = aop; d.in0 = ra_d;
    d.c_in = 0; d.c_dst = 0; d.c_wd = 0;
    case (kind)
      1: begin d.in1 = rb_d; d.dst = rc; d.we = 1; d.c_in = 1; d.c_dst = 1; end
      2: begin d.in1 = {16'h0, imm}; d.dst = rb; d.we = 1; d.c_in = 1; d.c_dst = 1; end
      3, 5: begin
        d.in1 = 32'(simm); d.dst = rb; d.we = 1; d.c_in = 1; d.c_dst = 1;
        if (kind == 5) d.mop = 1;
      end
      4: begin d.in1 = {27'h0, imm[4:0]}; d.dst = rb; d.we = 1; d.c_in = 1; d.c_dst = 1; end
      6: begin d.in1 = 32'(simm); d.mop = 2; d.wd = rb_d; d.c_in = 1; d.c_wd = 1; end
      0: d.exc = 1;
      default: ;
    endcase

    if (reset || flush) e = bubble();
    else if (stall) e = e;
    else if (haz || !if_en) e = bubble();
    else e = d;

    @(posedge clk);
    #1;
    chk("id_en", id_en, e.en);
    chk("id_gpr_we", id_gpr_we, e.we);
    chk("id_pc", id_pc, e.pc);
    chk("id_alu_op", id_alu_op, e.aop);
    chk("id_mem_op", id_mem_op, e.mop);
    chk("id_exp_code", id_exp_code, e.exc);
    if (e.c_in) begin
      chk("id_alu_in_0", id_alu_in_0, e.in0);
      chk("id_alu_in_1", id_alu_in_1, e.in1);
    end
    if (e.c_dst) chk("id_dst_addr", id_dst_addr, e.dst);
    if (e.c_wd)  chk("id_mem_wr_data", id_mem_wr_data, e.wd);
  endtask

  task automatic idle();
    reset = 0; stall = 0; flush = 0; if_en = 0; if_pc = 0; if_insn = 0;
    gpr_rd_data_0 = 0; gpr_rd_data_1 = 0;
    ex_en = 0; ex_gpr_we = 0; ex_dst_addr = 0; ex_mem_op = 0; ex_fwd_data = 0;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] ra,
                                     input logic [4:0] rb, input logic [15:0] low);
    return {op, ra, rb, low};
  endfunction

  localparam logic [5:0] VALID_OPS [20] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
      6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h10, 6'h11, 6'h16, 6'h17};

  initial begin
    idle();
    e = bubble();
    reset = 1;
    cycle();
    cycle();
    chk("reset id_en", id_en, 0);
    chk("reset id_alu_op", id_alu_op, 0);
    idle();

    // ADDSR r3,r1,r2
    if_en = 1; if_pc = 32'h40; if_insn = mk(6'h06, 5'd1, 5'd2, {5'd3, 11'd0});
    gpr_rd_data_0 = 5; gpr_rd_data_1 = 7;
    cycle();
    chk("addsr alu_op", id_alu_op, 4);
    chk("addsr in_0", id_alu_in_0, 5);
    chk("addsr in_1", id_alu_in_1, 7);
    chk("addsr dst", id_dst_addr, 3);
    chk("addsr we/en", {id_gpr_we, id_en}, 2'b11);

    // ORI / ADDSI with the same immediate
    if_insn = mk(6'h03, 5'd1, 5'd4, 16'h8001); gpr_rd_data_0 = 0;
    cycle();
    chk("ori in_1", id_alu_in_1, 32'h0000_8001);
    if_insn = mk(6'h07, 5'd1, 5'd4, 16'h8001);
    cycle();
    chk("addsi in_1", id_alu_in_1, 32'hFFFF_8001);

    // EX forwarding of r1
    ex_en = 1; ex_gpr_we = 1; ex_dst_addr = 1; ex_mem_op = 0; ex_fwd_data = 32'h11;
    gpr_rd_data_0 = 32'h99; if_insn = mk(6'h08, 5'd1, 5'd2, {5'd3, 11'd0});
    cycle();
    chk("fwd in_0", id_alu_in_0, 32'h11);

    // Load-use: SUBSR reads r2, ORI does not
    ex_dst_addr = 2; ex_mem_op = 1; if_insn = mk(6'h0A, 5'd1, 5'd2, {5'd3, 11'd0});
    #1 chk("subsr ld_hazard", ld_hazard, 1);
    cycle();
    chk("hazard bubble en", id_en, 0);
    chk("hazard bubble alu_op", id_alu_op, 0);
    if_insn = mk(6'h03, 5'd5, 5'd2, 16'h0003);
    #1 chk("ori ld_hazard", ld_hazard, 0);
    cycle();
    idle();

    // BE at 0x100, imm -1 -> target 0x100
    if_en = 1; if_pc = 32'h100; if_insn = mk(6'h10, 5'd1, 5'd2, 16'hFFFF);
    gpr_rd_data_0 = 32'h1234; gpr_rd_data_1 = 32'h1234;
    #1 chk("be taken", br_taken, 1);
    chk("be addr", br_addr, 32'h100);
    cycle();
    gpr_rd_data_1 = 32'h1235;
    #1 chk("be not taken", br_taken, 0);
    cycle();

    // Undefined opcode, then stall x2, flush+stall, reset during stall
    if_insn = mk(6'h3F, 5'd1, 5'd2, 16'h0);
    cycle();
    chk("undef exp", id_exp_code, 1);
    chk("undef en/we", {id_en, id_gpr_we}, 2'b10);
    stall = 1; if_insn = mk(6'h02, 5'd1, 5'd2, {5'd6, 11'd0});
    cycle();
    cycle();
    chk("stall held exp", id_exp_code, 1);
    flush = 1;
    cycle();
    chk("flush+stall en", id_en, 0);
    flush = 0; stall = 0;
    cycle();
    stall = 1; reset = 1;
    cycle();
    chk("reset mid-stall en", id_en, 0);
    idle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(63) == 0);
      flush = ($urandom_range(15) == 0);
      stall = ($urandom_range(7) == 0);
      if_en = ($urandom_range(7) != 0);
      if_pc = $urandom;
      if ($urandom_range(9) == 0)
        if_insn = $urandom;
      else
        if_insn = mk(VALID_OPS[$urandom_range(19)], 5'($urandom_range(7)),
                     5'($urandom_range(7)), 16'($urandom));
      gpr_rd_data_0 = $urandom;
      gpr_rd_data_1 = ($urandom_range(1) == 0) ? gpr_rd_data_0 : $urandom;
      ex_en = $urandom_range(1);
      ex_gpr_we = $urandom_range(1);
      ex_dst_addr = 5'($urandom_range(7));
      ex_mem_op = 2'($urandom_range(2));
      ex_fwd_data = ($urandom_range(3) == 0) ? gpr_rd_data_1 : $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
